// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO: start, DATA_BITS LSB-first, optional parity, STOP_BITS stops.
// Optional parity bit and PARITY state are compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axi_valid,
  output logic                 axi_ready,
  input  logic [DATA_BITS-1:0] axi_data,
  input  logic                 parity_odd,
  output logic                 uart_tx,
  output logic                 busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 rdy_en;
  logic                 push, pop, full, baud_last, stop_last;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`else
  logic                 unused_parity;
  assign unused_parity = parity_odd;
`endif

  // rdy_en keeps axi_ready low until the first edge after reset release
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign axi_ready = rdy_en && !full;
  assign push      = axi_valid && axi_ready;
  assign head      = mem[rd_ptr];
  assign baud_last = (baud == CW'(CLKS_PER_BIT - 1));
  assign stop_last = (bit_cnt == BW'(STOP_BITS - 1));
  assign pop       = (count != '0) &&
                     ((state == IDLE) || (state == STOP && baud_last && stop_last));
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axi_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      baud <= (state == IDLE || baud_last) ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= head;
            uart_tx <= 1'b0;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            par_bit <= (^head) ^ parity_odd;
`endif
          end else begin
            uart_tx <= 1'b1;
          end
        end
        START: if (baud_last) begin
          uart_tx <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (baud_last) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            uart_tx <= par_bit;
            state   <= PARITY;
`else
            uart_tx <= 1'b1;
            state   <= STOP;
`endif
          end else begin
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (baud_last) begin
          uart_tx <= 1'b1;
          bit_cnt <= '0;
          state   <= STOP;
        end
`endif
        STOP: if (baud_last) begin
          if (stop_last) begin
            bit_cnt <= '0;
            // back-to-back: next start bit follows the last stop bit directly
            if (pop) begin
              shreg   <= head;
              uart_tx <= 1'b0;
              state   <= START;
`ifdef UART_TX_PARITY_EN
              par_bit <= (^head) ^ parity_odd;
`endif
            end else begin
              uart_tx <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 and 7-data/2-stop instances at CLKS_PER_BIT=4.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F1 = (1 + 8 + P + 1) * CPB;
  localparam int F2 = (1 + 7 + P + 2) * CPB;

  logic clk = 1'b0, rst = 1'b1, podd = 1'b0;
  logic valid1 = 1'b0, ready1, tx1, busy1;
  logic valid2 = 1'b0, ready2, tx2, busy2;
  logic [7:0] data1 = '0;
  logic [6:0] data2 = '0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .axi_valid(valid1), .axi_ready(ready1), .axi_data(data1),
    .parity_odd(podd), .uart_tx(tx1), .busy(busy1));

  uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .axi_valid(valid2), .axi_ready(ready2), .axi_data(data2),
    .parity_odd(podd), .uart_tx(tx2), .busy(busy2));

  typedef struct {
    logic [7:0] d;
    logic       podd;
    logic       par;   // hand-computed parity bit
  } vec_t;
  vec_t vt[7];

  int   n_vec = 0, n_miss = 0;
  logic exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add_frame(input logic [8:0] d, input int nd, input int ns, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) exp_q.push_back(d[i]);
    if (P != 0) exp_q.push_back(par);
    for (int i = 0; i < ns; i++) exp_q.push_back(1'b1);
  endtask

  // caller is positioned just after the edge that drives the start bit
  task automatic watch(input int which);
    int c;
    logic b;
    c = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        chk($sformatf("tx%0d_c%0d", which, c), (which == 1) ? tx1 : tx2, b);
        chk($sformatf("busy%0d_c%0d", which, c), (which == 1) ? busy1 : busy2, 1'b1);
        c++;
      end
    end
  endtask

  task automatic push1(input logic [7:0] d, input logic p);
    @(negedge clk);
    valid1 = 1'b1; data1 = d; podd = p;
    @(posedge clk); #1;
    valid1 = 1'b0; data1 = 8'hxx;
  endtask

  initial begin
    logic [7:0] w6[6];
    logic [6:0] w4[4];
    logic       bad;
    int         g;

    vt[0] = '{8'h55, 1'b0, 1'b0};
    vt[1] = '{8'hA5, 1'b0, 1'b0};
    vt[2] = '{8'hA5, 1'b1, 1'b1};
    vt[3] = '{8'h00, 1'b1, 1'b1};
    vt[4] = '{8'hFF, 1'b0, 1'b0};
    vt[5] = '{8'h80, 1'b0, 1'b1};
    vt[6] = '{8'h01, 1'b1, 1'b0};
    w6 = '{8'h11, 8'h22, 8'hC3, 8'h44, 8'h5A, 8'hE6};
    w4 = '{7'h7F, 7'h15, 7'h6A, 7'h33};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx1", tx1, 1'b1);     chk("rst_tx2", tx2, 1'b1);
    chk("rst_rdy1", ready1, 1'b0); chk("rst_rdy2", ready2, 1'b0);
    chk("rst_busy1", busy1, 1'b0); chk("rst_busy2", busy2, 1'b0);
    rst = 1'b0; #1;
    chk("rel_rdy1", ready1, 1'b0);
    @(negedge clk);
    chk("edge_rdy1", ready1, 1'b1); chk("edge_rdy2", ready2, 1'b1);

    // single frames into an idle block
    foreach (vt[i]) begin
      push1(vt[i].d, vt[i].podd);
      @(negedge clk);
      chk($sformatf("v%0d_prestart", i), tx1, 1'b1);
      add_frame({1'b0, vt[i].d}, 8, 1, vt[i].par);
      watch(1);
      @(negedge clk);
      chk($sformatf("v%0d_idle_tx", i), tx1, 1'b1);
      chk($sformatf("v%0d_idle_busy", i), busy1, 1'b0);
    end

    // six words with valid held: FIFO fills, then frames stream back-to-back
    podd = 1'b0;
    foreach (w6[i]) add_frame({1'b0, w6[i]}, 8, 1, ^w6[i]);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          valid1 = 1'b1; data1 = w6[k];
          g = 0;
          while (!ready1 && g < 400) begin @(negedge clk); g++; end
          chk($sformatf("w6_%0d_ready_tmo", k), ready1, 1'b1);
          @(posedge clk); #1;
          if (k == 4) begin
            @(negedge clk);
            chk("w6_full_ready", ready1, 1'b0);
          end
        end
        valid1 = 1'b0;
      end
      begin
        @(negedge clk); @(posedge clk); @(posedge clk);
        watch(1);
      end
    join
    @(negedge clk);
    chk("w6_idle_busy", busy1, 1'b0);
    chk("w6_idle_tx", tx1, 1'b1);

    // 7 data / 2 stop; 4th word pushed on the same edge frame 1 pops word 2
    foreach (w4[i]) add_frame({2'b0, w4[i]}, 7, 2, ^w4[i]);
    fork
      begin
        @(negedge clk);
        valid2 = 1'b1; data2 = w4[0];
        @(posedge clk); #1 data2 = w4[1];
        @(posedge clk); #1 data2 = w4[2];
        @(posedge clk); #1 valid2 = 1'b0;
        repeat (F2 - 2) @(posedge clk);
        #1;
        chk("pp_ready_before", ready2, 1'b1);
        valid2 = 1'b1; data2 = w4[3];
        @(posedge clk); #1 valid2 = 1'b0;
        chk("pp_ready_after", ready2, 1'b1);
      end
      begin
        @(negedge clk); @(posedge clk); @(posedge clk);
        watch(2);
      end
    join
    @(negedge clk);
    chk("w4_idle_busy", busy2, 1'b0);
    chk("w4_idle_tx", tx2, 1'b1);

    // reset in the middle of data bit 3 with two words queued
    @(negedge clk);
    valid1 = 1'b1; data1 = 8'h55;
    @(posedge clk); #1 data1 = 8'h12;
    @(posedge clk); #1 data1 = 8'h34;
    @(posedge clk); #1 valid1 = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    chk("rm_bit3_pre", tx1, 1'b0);
    chk("rm_busy_pre", busy1, 1'b1);
    rst = 1'b1; #1;
    chk("rm_tx_async", tx1, 1'b1);
    chk("rm_busy_async", busy1, 1'b0);
    chk("rm_rdy_async", ready1, 1'b0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rm_rdy_rel", ready1, 1'b0);
    @(negedge clk);
    chk("rm_rdy_edge", ready1, 1'b1);
    chk("rm_busy_edge", busy1, 1'b0);
    bad = 1'b0;
    repeat (2 * F1) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad = 1'b1;
    end
    chk("rm_quiet_after", bad, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 serializer. Accepts words over a valid/ready byte stream into a small FIFO. Serializes each word as start, data (LSB first), optional parity and 1 or 2 stop bits, with a programmable baud divider. Sits between the TDC result formatter and the chip's serial output pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
STOP_BITS, 1, number of stop bits; must be 1 or 2.
FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
axi_valid  in  1  input word valid.
axi_ready  out  1  FIFO can accept a word.
axi_data  in  DATA_BITS  input word.
parity_odd  in  1  parity sense, 1=odd, 0=even; sampled at start-bit entry; ignored without the macro.
uart_tx  out  1  serial line; idles high.
busy  out  1  high while the FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset (async assert, sync release): FIFO emptied, state IDLE, uart_tx=1, axi_ready=0, busy=0, baud and bit counters 0. On the first clk edge after release, axi_ready becomes 1.
- Reset mid-frame: uart_tx returns to 1 immediately; the in-flight frame and all queued words are discarded.
- Handshake: a word is pushed on a clk edge with axi_valid && axi_ready.
- axi_ready = !full, derived from the registered occupancy count.
- Simultaneous push and pop: occupancy is unchanged. Push while full cannot occur.
- axi_data is ignored when axi_valid=0. axi_valid may drop without a push.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: if the FIFO is non-empty, pop the head into a shift register, drive uart_tx<=0, go to START, and clear the baud counter. Otherwise drive uart_tx<=1.
- Every non-IDLE state holds uart_tx for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, and the state advances when it reaches CLKS_PER_BIT-1.
- START->DATA: drive bit 0.
- DATA: shift out LSB first. After DATA_BITS bits, go to PARITY if enabled, else STOP (uart_tx=1).
- STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap (back-to-back). Otherwise go to IDLE.
- Latency: a word pushed at edge N into an empty FIFO with the serializer idle is popped at edge N+1. uart_tx is low from edge N+1.
- Frame length = (1 + DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT cycles, with P = 1 if parity is enabled.
- busy = (state != IDLE) || (count != 0).
- Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
UART_TX_PARITY_EN
- Defined: the PARITY state is compiled in. The parity bit is the XOR of the data bits, inverted when parity_odd=1 (parity_odd is latched at the start of each frame). The frame gains one bit time.
- Undefined: no PARITY state, parity_odd is unused, and the frame is start + data + stop only.

Test Plan:
1. Defaults, CLKS_PER_BIT=4, push 0x55 into an idle block -> uart_tx: 4 cycles 0 (start), then 1,0,1,0,1,0,1,0 for 4 cycles each, then 4 cycles 1. busy is high for 40 cycles from edge N+1.
2. UART_TX_PARITY_EN defined, push 0xA5 with parity_odd=0 -> parity bit 0. Repeat with parity_odd=1 -> parity bit 1. Each frame is 11 bit times.
3. FIFO_DEPTH=4, axi_valid held high for 6 consecutive words -> 5 words accepted, then axi_ready=0. The 6th word is accepted on the cycle the 2nd word is popped, at the end of frame 1. All 6 frames go out back-to-back with no idle high gap between stop and start.
4. STOP_BITS=2, DATA_BITS=7, push 0x7F -> start, 7 ones, then 2*CLKS_PER_BIT cycles of 1. The next queued frame's start bit follows immediately.
5. Assert rst in the middle of DATA bit 3 with 2 words queued -> uart_tx=1 in the same cycle (async). After release, busy=0, the FIFO is empty, no frame is emitted, and axi_ready=1 one edge after release.
6. Push and pop in the same edge with the FIFO holding 2 words -> count stays 2, and the word order out equals the order in.
